// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline stage register with valid/ready handshake,
// synchronous flush with selective bit retention (KEEP_MASK), and an optional
// skid entry.
//
// Build option: define PIPE_STAGE_SKID_EN to compile in the skid entry.
//   - defined:   two entries (main + skid), in_ready depends only on registered
//                state and flush, count ranges 0..2, a released stall costs no
//                bubble.
//   - undefined: single entry, in_ready follows out_ready combinationally,
//                count[1] is always 0.
//
// Handshake: a payload moves across a port on a rising CLK edge exactly when
// both valid and ready are high in that cycle (in_valid & in_ready on the
// input side, out_valid & out_ready on the output side). A producer holding
// valid must keep its data stable until the transfer; this stage does the same
// on its output: once out_valid rises, out_data holds until it is taken or a
// flush squashes it.
module pipe_stage_reg #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] KEEP_MASK = '0
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    input  logic             flush_keep,
    output logic [1:0]       count
);

    // Main entry: always the one presented to the consumer.
    logic             main_valid;
    logic [WIDTH-1:0] main_data;

    logic in_xfer;
    logic out_xfer;

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = main_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN

    // Skid entry: catches the payload accepted while main is stalled.
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    // Ready is a function of registered state and flush only; a flush always
    // consumes the input so the squash can never back up the producer.
    assign in_ready = nRST & (flush | ~skid_valid);

    // Skid implies main is full, so occupancy is encoded directly.
    assign count = {skid_valid, main_valid & ~skid_valid};

    // Entry update: reset, then flush (with optional kept bubble), then normal flow.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
            if (flush_keep && in_valid) begin
                main_valid <= 1'b1;
                main_data  <= in_data & KEEP_MASK;
            end else begin
                main_valid <= 1'b0;
                main_data  <= '0;
            end
        end else if (skid_valid) begin
            // in_ready is low here, so only the skid-to-main move can happen.
            if (out_xfer) begin
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end
        end else if (!main_valid) begin
            if (in_xfer) begin
                main_valid <= 1'b1;
                main_data  <= in_data;
            end
        end else begin
            if (out_xfer && in_xfer) begin
                main_data <= in_data;
            end else if (out_xfer) begin
                main_valid <= 1'b0;
            end else if (in_xfer) begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
            end
        end
    end

`else

    // Single entry: space frees up in the same cycle the consumer takes main.
    assign in_ready = nRST & (flush | ~main_valid | out_ready);

    assign count = {1'b0, main_valid};

    // Entry update: reset, then flush (with optional kept bubble), then normal flow.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            main_valid <= 1'b0;
            main_data  <= '0;
        end else if (flush) begin
            if (flush_keep && in_valid) begin
                main_valid <= 1'b1;
                main_data  <= in_data & KEEP_MASK;
            end else begin
                main_valid <= 1'b0;
                main_data  <= '0;
            end
        end else if (in_xfer) begin
            main_valid <= 1'b1;
            main_data  <= in_data;
        end else if (out_xfer) begin
            main_valid <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed, table-driven bench for pipe_stage_reg with
// WIDTH=8 and KEEP_MASK=8'h80. The vector table follows whichever build of the
// stage is compiled (PIPE_STAGE_SKID_EN defined or not); a streaming sequence
// with an expected-value queue follows the table.
module tb_pipe_stage_reg;

    localparam int          W    = 8;
    localparam logic [W-1:0] MASK = 8'h80;

    logic         CLK;
    logic         nRST;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         flush;
    logic         flush_keep;
    logic [1:0]   count;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic         nrst;
        logic         iv;
        logic [W-1:0] id;
        logic         ordy;
        logic         fl;
        logic         fk;
        logic         exp_ir;
        logic         exp_ov;
        logic [W-1:0] exp_od;
        logic         chk_od;
        logic [1:0]   exp_cnt;
    } vec_t;

    vec_t vecs[$];

    pipe_stage_reg #(
        .WIDTH     (W),
        .KEEP_MASK (MASK)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush      (flush),
        .flush_keep (flush_keep),
        .count      (count)
    );

    // Clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic add(input logic nrst, input logic iv, input logic [W-1:0] id,
                       input logic ordy, input logic fl, input logic fk,
                       input logic exp_ir, input logic exp_ov, input logic [W-1:0] exp_od,
                       input logic chk_od, input logic [1:0] exp_cnt);
        vec_t v;
        v.nrst = nrst; v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl; v.fk = fk;
        v.exp_ir = exp_ir; v.exp_ov = exp_ov; v.exp_od = exp_od;
        v.chk_od = chk_od; v.exp_cnt = exp_cnt;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic nrst, input logic iv, input logic [W-1:0] id,
                         input logic ordy, input logic fl, input logic fk);
        nRST       = nrst;
        in_valid   = iv;
        in_data    = id;
        out_ready  = ordy;
        flush      = fl;
        flush_keep = fk;
    endtask

    initial begin
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        //   nrst iv  id     ordy fl  fk   | ir  ov  od     chk cnt
        add(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0); // reset
        add(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0); // reset
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0); // release
`ifdef PIPE_STAGE_SKID_EN
        add(1'b1, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b1, 2'd1); // A1 -> main
        add(1'b1, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b1, 2'd2); // A2 -> skid
        add(1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 2'd2); // A3 held
        add(1'b1, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA2, 1'b1, 2'd1); // A1 out, skid->main
        add(1'b1, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA3, 1'b1, 2'd1); // A2 out, A3 in
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0); // A3 out
        add(1'b1, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB1, 1'b1, 2'd1);
        add(1'b1, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB1, 1'b1, 2'd2);
        add(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0); // flush from 2
        add(1'b1, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h7E, 1'b1, 2'd1);
        add(1'b1, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h7E, 1'b1, 2'd2);
`else
        add(1'b1, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b1, 2'd1); // A1 -> main
        add(1'b1, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 2'd1); // stalled
        add(1'b1, 1'b1, 8'hA2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA2, 1'b1, 2'd1); // pass-through
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0); // drain
        add(1'b1, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB1, 1'b1, 2'd1);
        add(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0); // flush
        add(1'b1, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h7E, 1'b1, 2'd1);
`endif
        add(1'b1, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 2'd1); // kept bubble
        add(1'b1, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0); // keep, no in_valid
        add(1'b1, 1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0); // back-to-back flush
        add(1'b1, 1'b1, 8'hC5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 2'd1); // last one kept
        add(1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0); // flush + out xfer
        add(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 2'd1);
        add(1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0); // reset wins
        add(1'b1, 1'b1, 8'hF1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 2'd1); // flush on release
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0); // drain

        // Table: drive at negedge, check comb in_ready before the edge,
        // registered outputs just after it.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            drive(vecs[i].nrst, vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl, vecs[i].fk);
            #1;
            check($sformatf("v%0d in_ready", i), {7'b0, in_ready}, {7'b0, vecs[i].exp_ir});
            @(posedge CLK);
            #1;
            check($sformatf("v%0d out_valid", i), {7'b0, out_valid}, {7'b0, vecs[i].exp_ov});
            check($sformatf("v%0d count", i), {6'b0, count}, {6'b0, vecs[i].exp_cnt});
            if (vecs[i].chk_od)
                check($sformatf("v%0d out_data", i), out_data, vecs[i].exp_od);
        end

        // Streaming 01..10 with out_ready held high: one per cycle, one cycle late.
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLK);
            drive(1'b1, 1'b1, W'(k), 1'b1, 1'b0, 1'b0);
            #1;
            check($sformatf("stream%0d in_ready", k), {7'b0, in_ready}, 8'h01);
            if (in_ready) exp_q.push_back(W'(k));
            @(posedge CLK);
            #1;
            check($sformatf("stream%0d out_valid", k), {7'b0, out_valid}, 8'h01);
            if (exp_q.size() > 0)
                check($sformatf("stream%0d out_data", k), out_data, exp_q.pop_front());
            else
                check($sformatf("stream%0d queue", k), 8'h00, 8'h01);
        end
        @(negedge CLK);
        drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        check("stream_end out_valid", {7'b0, out_valid}, 8'h00);
        check("stream_end count", {6'b0, count}, 8'h00);
        check("stream_end leftover", W'(exp_q.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
